// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Groups the hazard controller's request and response signals.
//   master : pipeline side. Drives rdy_in, stall_req, flush_req and flush_depth.
//            Receives stall, flush and flushing.
//   slave  : pipe_hazard_ctrl. Takes the requests and drives the hold/kill vectors.
// Build option PIPE_HAZARD_PERF_EN adds the performance counter outputs
// stall_cycles and flush_count, which the slave drives.
interface pipe_hazard_ctrl_if #(
   parameter int NSTAGE  = 5,
   parameter int DEPTH_W = 3,
   parameter int CNT_W   = 32
);
   logic                rdy_in;
   logic [NSTAGE-1:0]   stall_req;
   logic                flush_req;
   logic [DEPTH_W-1:0]  flush_depth;
   logic [NSTAGE:0]     stall;
   logic [NSTAGE:0]     flush;
   logic                flushing;
`ifdef PIPE_HAZARD_PERF_EN
   logic [CNT_W-1:0]    stall_cycles;
   logic [CNT_W-1:0]    flush_count;

   modport master (output rdy_in, stall_req, flush_req, flush_depth,
                   input  stall, flush, flushing, stall_cycles, flush_count);
   modport slave  (input  rdy_in, stall_req, flush_req, flush_depth,
                   output stall, flush, flushing, stall_cycles, flush_count);
`else
   modport master (output rdy_in, stall_req, flush_req, flush_depth,
                   input  stall, flush, flushing);
   modport slave  (input  rdy_in, stall_req, flush_req, flush_depth,
                   output stall, flush, flushing);
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline stall/flush controller for the RV32I core.
// It merges the per-stage stall requests, the mispredict flush and the global ready
// into hold (stall) and kill (flush) vectors for pc_reg, if_id, id_ex, ex_mem and mem_wb.
// Ports:
//   clk_in  : clock
//   rst_in  : asynchronous reset, active high
//   bus     : pipe_hazard_ctrl_if.slave
//             inputs  rdy_in, stall_req, flush_req, flush_depth
//             outputs stall, flush, flushing
// Build option PIPE_HAZARD_PERF_EN adds the stall_cycles and flush_count counters.
//
// state | meaning
// IDLE  | no flush window; stall follows the requests
// FLUSH | flush window active; the front depth_q stages are killed and their stall requests are masked
module pipe_hazard_ctrl #(
   parameter int NSTAGE    = 5,
   parameter int FLUSH_LEN = 2,
   parameter int DEPTH_W   = 3,
   parameter int CNT_W     = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [CW-1:0]      CNT_LOAD  = CW'(FLUSH_LEN - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NSTAGE);

   if (FLUSH_LEN < 1 || (2 ** DEPTH_W) <= NSTAGE || CNT_W < 1) begin : g_bad_param
      $error("pipe_hazard_ctrl: illegal parameter combination");
   end

   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d, depth_clamp;
   logic [NSTAGE-1:0]   kill_mask, req_eff;
   logic [NSTAGE:0]     stall_o, flush_o;
   logic                in_flush;

   always_comb begin
      depth_clamp = bus.flush_depth;
      if (bus.flush_depth == '0)
         depth_clamp = DEPTH_W'(1);
      else if (bus.flush_depth > DEPTH_MAX)
         depth_clamp = DEPTH_MAX;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         depth_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         depth_q <= depth_d;
      end
   end

   // Everything freezes while rdy_in is low. A flush_req seen in FLUSH restarts the window.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      depth_d = depth_q;
      if (bus.rdy_in) begin
         case (state_q)
            IDLE: begin
               if (bus.flush_req) begin
                  state_d = FLUSH;
                  depth_d = depth_clamp;
                  cnt_d   = CNT_LOAD;
               end
            end
            FLUSH: begin
               if (bus.flush_req) begin
                  depth_d = depth_clamp;
                  cnt_d   = CNT_LOAD;
               end else if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_flush  = (state_q == FLUSH);
      kill_mask = '0;
      for (int i = 0; i < NSTAGE; i++)
         kill_mask[i] = in_flush && (i < int'(depth_q));
      req_eff = bus.stall_req & ~kill_mask;

      // A stall request from stage k holds that stage, every stage in front of it, and the PC.
      stall_o = '0;
      if (rst_in || !bus.rdy_in) begin
         stall_o = '1;
      end else begin
         stall_o[0] = |req_eff;
         for (int j = 1; j <= NSTAGE; j++)
            stall_o[j] = |(req_eff >> (j - 1));
      end

      flush_o = '0;
      if (in_flush && bus.rdy_in)
         flush_o[NSTAGE:1] = kill_mask;
   end

   assign bus.stall    = stall_o;
   assign bus.flush    = flush_o;
   assign bus.flushing = in_flush;

`ifdef PIPE_HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (bus.rdy_in && stall_o[0])
            stall_cycles_q <= stall_cycles_q + 1'b1;
         if (bus.rdy_in && bus.flush_req)
            flush_count_q <= flush_count_q + 1'b1;
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic [5:0] stall;
      logic [5:0] flush;
      logic       fl;
      string      name;
   } exp_t;

   logic clk_in;
   logic rst_in;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
`ifdef PIPE_HAZARD_PERF_EN
   int   m_stall_cycles = 0;
   int   m_flush_count  = 0;
`endif

   pipe_hazard_ctrl_if #(.NSTAGE(5), .DEPTH_W(3), .CNT_W(32)) bus ();

   pipe_hazard_ctrl #(.NSTAGE(5), .FLUSH_LEN(2), .DEPTH_W(3), .CNT_W(32)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply(input logic r, input logic rd, input logic [4:0] req,
                        input logic fr, input logic [2:0] d,
                        input logic [5:0] es, input logic [5:0] ef, input logic efl,
                        input string nm);
      exp_t e;
      @(posedge clk_in);
      #1;
      rst_in          = r;
      bus.rdy_in      = rd;
      bus.stall_req   = req;
      bus.flush_req   = fr;
      bus.flush_depth = d;
      e.stall = es;
      e.flush = ef;
      e.fl    = efl;
      e.name  = nm;
      q.push_back(e);
`ifdef PIPE_HAZARD_PERF_EN
      if (r) begin
         m_stall_cycles = 0;
         m_flush_count  = 0;
      end else begin
         if (rd && es[0]) m_stall_cycles++;
         if (rd && fr)    m_flush_count++;
      end
`endif
   endtask

   // monitor: outputs are combinational, so each vector is checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.stall !== e.stall || bus.flush !== e.flush || bus.flushing !== e.fl) begin
               errors++;
               $display("FAIL %s: got stall=%b flush=%b flushing=%b, expected stall=%b flush=%b flushing=%b",
                        e.name, bus.stall, bus.flush, bus.flushing, e.stall, e.flush, e.fl);
            end
         end
      end
   end

   initial begin
      rst_in          = 1'b1;
      bus.rdy_in      = 1'b0;
      bus.stall_req   = '0;
      bus.flush_req   = 1'b0;
      bus.flush_depth = '0;

      // reset and stall encoding
      apply(1, 0, 5'b10101, 1, 3, 6'b111111, 6'b0, 0, "reset_a");
      apply(1, 1, 5'b00000, 0, 0, 6'b111111, 6'b0, 0, "reset_b");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b0, 0, "release");
      apply(0, 1, 5'b00001, 0, 0, 6'b000011, 6'b0, 0, "enc_if");
      apply(0, 1, 5'b01010, 0, 0, 6'b011111, 6'b0, 0, "enc_id_mem");
      apply(0, 1, 5'b00100, 0, 0, 6'b001111, 6'b0, 0, "enc_ex");
      apply(0, 1, 5'b10000, 0, 0, 6'b111111, 6'b0, 0, "enc_wb");
      apply(0, 0, 5'b00000, 0, 0, 6'b111111, 6'b0, 0, "rdy_low_idle");
      // basic flush window depth 2
      apply(0, 1, 5'b00000, 1, 2, 6'b000000, 6'b000000, 0, "fl2_req");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000110, 1, "fl2_c1");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000110, 1, "fl2_c2");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "fl2_end");
      // masking during flush
      apply(0, 1, 5'b00000, 1, 2, 6'b000000, 6'b000000, 0, "mask_req");
      apply(0, 1, 5'b00011, 0, 0, 6'b000000, 6'b000110, 1, "mask_killed");
      apply(0, 1, 5'b01000, 0, 0, 6'b011111, 6'b000110, 1, "mask_mem_live");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "mask_end");
      // restart on last flush cycle
      apply(0, 1, 5'b00000, 1, 2, 6'b000000, 6'b000000, 0, "rs_req");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000110, 1, "rs_c1");
      apply(0, 1, 5'b00000, 1, 3, 6'b000000, 6'b000110, 1, "rs_c2_req");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b001110, 1, "rs_d3_c1");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b001110, 1, "rs_d3_c2");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "rs_end");
      // rdy low mid flush
      apply(0, 1, 5'b00000, 1, 1, 6'b000000, 6'b000000, 0, "frz_req");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000010, 1, "frz_c1");
      apply(0, 0, 5'b00000, 0, 0, 6'b111111, 6'b000000, 1, "frz_a");
      apply(0, 0, 5'b00011, 0, 0, 6'b111111, 6'b000000, 1, "frz_b");
      apply(0, 0, 5'b00000, 0, 0, 6'b111111, 6'b000000, 1, "frz_c");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000010, 1, "frz_resume");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "frz_end");
      // flush_req ignored while rdy low, accepted once rdy returns
      apply(0, 0, 5'b00000, 1, 2, 6'b111111, 6'b000000, 0, "hold_req_rdy0");
      apply(0, 1, 5'b00000, 1, 2, 6'b000000, 6'b000000, 0, "hold_req_rdy1");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000110, 1, "hold_c1");
      // async reset aborts the window
      apply(1, 1, 5'b00000, 0, 0, 6'b111111, 6'b000000, 0, "rst_mid");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "rst_after");
      // depth clamping
      apply(0, 1, 5'b00000, 1, 0, 6'b000000, 6'b000000, 0, "d0_req");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000010, 1, "d0_c1");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000010, 1, "d0_c2");
      apply(0, 1, 5'b00000, 1, 7, 6'b000000, 6'b000000, 0, "d7_req");
      apply(0, 1, 5'b11111, 0, 0, 6'b000000, 6'b111110, 1, "d7_c1_masked");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b111110, 1, "d7_c2");
      apply(0, 1, 5'b00000, 0, 0, 6'b000000, 6'b000000, 0, "d7_end");

      repeat (2) @(posedge clk_in);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      if (bus.stall_cycles !== 32'(m_stall_cycles)) begin
         errors++;
         $display("FAIL stall_cycles: got %0d expected %0d", bus.stall_cycles, m_stall_cycles);
      end
      checks++;
      if (bus.flush_count !== 32'(m_flush_count)) begin
         errors++;
         $display("FAIL flush_count: got %0d expected %0d", bus.flush_count, m_flush_count);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
